// File: rtl/norm_round.sv
// norm_round: normalise-and-round stage of the SRFPU datapath.
// Stage 1 registers the left-justified mantissa and adjusted exponent.
// Stage 2 holds the normalised beat and rounds it at the output, so the
// stochastic LFSR draw belongs to the beat that actually leaves the block
// and all outputs stay frozen while the consumer stalls.
module norm_round #(
  parameter int          exp_width      = 8,
  parameter int          mant_width     = 23,
  parameter int          num_round_bits = 3,
  parameter logic [31:0] lfsr_seed      = 32'hACE1_2024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sign,
  input  logic [exp_width+1:0]               in_exp,
  input  logic [mant_width+num_round_bits:0] in_mant,
  input  logic [exp_width+1:0]               in_lz,
  input  logic                               rnd_mode,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_sign,
  output logic [exp_width-1:0]               out_exp,
  output logic [mant_width-1:0]              out_mant,
  output logic [2:0]                         out_flags
);

  localparam int W   = mant_width + num_round_bits + 1;
  localparam int EW2 = exp_width + 2;
  localparam int RB  = num_round_bits;
  localparam int MW  = mant_width;

  localparam logic [EW2-1:0]      LZ_ZERO   = EW2'(W);
  localparam logic signed [EW2:0] EXP_MAX   = (EW2+1)'((1 << exp_width) - 1);
  localparam logic signed [EW2:0] EXP_ZERO  = '0;
  localparam logic [RB-1:0]       HALF      = RB'(1 << (RB - 1));
  // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0]         LFSR_TAPS = 32'h8020_0003;

  typedef struct packed {
    logic           sign;
    logic           mode;
    logic           zero;
    logic [W-1:0]   nm;
    logic [EW2-1:0] ne;
  } stage_t;

  logic [2:1]  vld_pipe_q, vld_pipe_d;
  stage_t      s1_q, s1_d, s2_q, s2_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic        in_fire, out_fire, s1_adv;

  // handshake: stage 1 moves whenever stage 2 is empty or emptying this cycle
  assign out_valid = vld_pipe_q[2];
  assign out_fire  = vld_pipe_q[2] & out_ready;
  assign s1_adv    = vld_pipe_q[1] & (~vld_pipe_q[2] | out_ready);
  assign in_ready  = ~vld_pipe_q[1] | s1_adv;
  assign in_fire   = in_valid & in_ready;

  // stage valid bits: fill on accept/advance, drain on advance/emit
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (in_fire)     vld_pipe_d[1] = 1'b1;
    else if (s1_adv) vld_pipe_d[1] = 1'b0;
    if (s1_adv)        vld_pipe_d[2] = 1'b1;
    else if (out_fire) vld_pipe_d[2] = 1'b0;
  end

  // stage 1 normalise: left-justify mantissa, pull exponent down by the shift
  always_comb begin
    s1_d = s1_q;
    if (in_fire) begin
      s1_d.sign = in_sign;
      s1_d.mode = rnd_mode;
      s1_d.zero = (in_lz >= LZ_ZERO);
      s1_d.nm   = in_mant << in_lz;
      s1_d.ne   = in_exp - in_lz;
    end
  end

  // stage 2 capture: takes the stage 1 beat only when it advances
  always_comb begin
    s2_d = s1_adv ? s1_q : s2_q;
  end

  logic [MW-1:0]      frac;
  logic [RB-1:0]      rbits;
  logic [RB:0]        sto_sum;
  logic [MW:0]        frac_sum;
  logic signed [EW2:0] exp_r;
  logic               rne_up, sto_up, rnd_up, ovf, unf;
  logic               unused_hidden;

  // the hidden bit only marks position; rounding works on F and R
  assign unused_hidden = s2_q.nm[W-1];

  // stage 2 round: RNE or stochastic increment, carry into exponent, range check
  always_comb begin
    frac     = s2_q.nm[RB +: MW];
    rbits    = s2_q.nm[RB-1:0];
    rne_up   = (rbits > HALF) || ((rbits == HALF) && frac[0]);
    sto_sum  = {1'b0, rbits} + {1'b0, lfsr_q[RB-1:0]};
    sto_up   = sto_sum[RB];
    rnd_up   = s2_q.mode ? sto_up : rne_up;
    frac_sum = {1'b0, frac} + {{MW{1'b0}}, rnd_up};
    // exponent is widened one bit so the carry increment cannot wrap
    exp_r    = $signed({s2_q.ne[EW2-1], s2_q.ne}) + $signed({{EW2{1'b0}}, frac_sum[MW]});
    ovf      = (exp_r >= EXP_MAX);
    unf      = (exp_r <= EXP_ZERO);
  end

  // output mux: zeros whenever no beat is held, else zero/inf/flush/normal result
  always_comb begin
    out_sign  = 1'b0;
    out_exp   = '0;
    out_mant  = '0;
    out_flags = '0;
    if (vld_pipe_q[2]) begin
      out_sign = s2_q.sign;
      if (!s2_q.zero) begin
        if (ovf) begin
          out_exp   = '1;
          out_flags = 3'b101;
        end else if (unf) begin
          out_flags = 3'b011;
        end else begin
          out_exp   = exp_r[exp_width-1:0];
          out_mant  = frac_sum[MW-1:0];
          out_flags = {2'b00, |rbits};
        end
      end
    end
  end

  // LFSR steps once per emitted stochastic beat, so stalls never change the draw
  always_comb begin
    lfsr_d = lfsr_q;
    if (out_fire && s2_q.mode)
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  end

  // state registers; reset drops every in-flight beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      lfsr_q     <= lfsr_seed;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lfsr_q     <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_norm_round.sv
// tb_norm_round: directed vector table, backpressure/reset sequences, and a
// randomized stream scored against a plain-arithmetic reference model.
module tb_norm_round;

  localparam logic [31:0] SEED = 32'hACE1_2024;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic [9:0]  lz;
    logic        mode;
  } beat_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
    logic [2:0]  flags;
  } res_t;

  typedef struct {
    beat_t b;
    res_t  r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_sign, rnd_mode;
  logic [9:0]  in_exp, in_lz;
  logic [26:0] in_mant;
  logic        out_valid, out_ready, out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_mant;
  logic [2:0]  out_flags;

  int errors = 0;
  int checks = 0;
  int emitted = 0;
  beat_t q_in[$];
  res_t  outq[$];
  logic [31:0] mlfsr = SEED;

  norm_round #(.exp_width(8), .mant_width(23), .num_round_bits(3), .lfsr_seed(SEED)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .in_lz(in_lz), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // reference: shift, split into F/R, decide increment, then range-check
  function automatic res_t model(input beat_t b, input logic [31:0] lf);
    res_t   r;
    longint nm;
    int     ne, f, rb, up;
    r = '0;
    r.sign = b.sign;
    if (int'(b.lz) >= 27) return r;
    nm = (longint'(b.mant) << b.lz) % (longint'(1) << 27);
    ne = int'($signed(b.exp)) - int'(b.lz);
    rb = int'(nm % 8);
    f  = int'((nm / 8) % (longint'(1) << 23));
    if (b.mode) up = (rb + int'(lf[2:0]) >= 8) ? 1 : 0;
    else        up = (rb > 4 || (rb == 4 && f % 2 == 1)) ? 1 : 0;
    f += up;
    if (f == (1 << 23)) begin
      f = 0;
      ne++;
    end
    if (ne >= 255) begin
      r.exp = 8'hFF;
      r.flags = 3'b101;
    end else if (ne <= 0) begin
      r.flags = 3'b011;
    end else begin
      r.exp = 8'(ne);
      r.mant = 23'(f);
      r.flags = {2'b00, rb != 0};
    end
    return r;
  endfunction

  function automatic res_t dut_res();
    return {out_sign, out_exp, out_mant, out_flags};
  endfunction

  function automatic beat_t mkb(input bit s, input int e, input logic [26:0] m, input int lz, input bit md);
    beat_t b;
    b.sign = s; b.exp = 10'(e); b.mant = m; b.lz = 10'(lz); b.mode = md;
    return b;
  endfunction

  function automatic res_t mkr(input bit s, input int e, input int m, input logic [2:0] fl);
    res_t r;
    r.sign = s; r.exp = 8'(e); r.mant = 23'(m); r.flags = fl;
    return r;
  endfunction

  function automatic logic [26:0] mm(input int f, input int r);
    return {1'b1, 23'(f), 3'(r)};
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.sign = 1'($urandom);
    b.exp  = 10'(int'($urandom_range(0, 400)) - 100);
    b.mant = 27'($urandom);
    if ($urandom_range(0, 7) == 0) b.mant[2:0] = 3'b100;
    if ($urandom_range(0, 7) == 0) b.mant[25:3] = '1;
    b.lz   = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(27, 40)) : 10'($urandom_range(0, 26));
    b.mode = 1'($urandom);
    return b;
  endfunction

  // scoreboard: inputs queued on accept, each emitted beat scored in order
  always @(negedge clk) begin
    beat_t mb;
    res_t  mr, ar;
    if (!rst_n) begin
      q_in.delete();
      mlfsr = SEED;
    end else begin
      if (out_valid && out_ready) begin
        ar = dut_res();
        if (q_in.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got beat %0h with nothing pending, want none", ar);
        end else begin
          mb = q_in.pop_front();
          mr = model(mb, mlfsr);
          chk("beat", ar, mr);
          if (mb.mode) mlfsr = lfsr_step(mlfsr);
        end
        outq.push_back(ar);
        emitted++;
      end
      if (in_valid && in_ready)
        q_in.push_back({in_sign, in_exp, in_mant, in_lz, rnd_mode});
    end
  end

  task automatic send(input beat_t b);
    int t;
    t = 0;
    in_valid = 1'b1;
    {in_sign, in_exp, in_mant, in_lz, rnd_mode} = b;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q_in.size() != 0 || out_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", q_in.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  vec_t  tv[11];
  res_t  run1[$];
  beat_t bp[10];
  beat_t sb;
  int    ups, mism, stale, e0;
  bit    done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0; in_lz = 0; rnd_mode = 0;
    out_ready = 1;

    tv[0]  = '{mkb(0, 130, 27'h0400000, 4, 0),  mkr(0, 126, 0, 3'b000)};
    tv[1]  = '{mkb(0, 127, mm(1, 4), 0, 0),     mkr(0, 127, 2, 3'b001)};
    tv[2]  = '{mkb(0, 127, mm(2, 4), 0, 0),     mkr(0, 127, 2, 3'b001)};
    tv[3]  = '{mkb(0, 127, mm(23'h7FFFFF, 7), 0, 0), mkr(0, 128, 0, 3'b001)};
    tv[4]  = '{mkb(0, 254, mm(23'h7FFFFF, 7), 0, 0), mkr(0, 255, 0, 3'b101)};
    tv[5]  = '{mkb(1, 2, 27'h0400000, 3, 0),    mkr(1, 0, 0, 3'b011)};
    tv[6]  = '{mkb(1, 100, 27'h0, 27, 0),       mkr(1, 0, 0, 3'b000)};
    tv[7]  = '{mkb(0, 127, mm(16, 5), 0, 0),    mkr(0, 127, 17, 3'b001)};
    tv[8]  = '{mkb(0, 50, 27'h123, 30, 0),      mkr(0, 0, 0, 3'b000)};
    tv[9]  = '{mkb(0, 1, mm(5, 0), 0, 0),       mkr(0, 1, 5, 3'b000)};
    tv[10] = '{mkb(0, 254, mm(3, 0), 0, 0),     mkr(0, 254, 3, 3'b000)};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", dut_res(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed table: latency 2 and exact results
    foreach (tv[i]) begin
      send(tv[i].b);
      @(negedge clk);
      chk($sformatf("lat_early_%0d", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("lat_valid_%0d", i), out_valid, 1);
      chk($sformatf("vec_%0d", i), dut_res(), tv[i].r);
      @(posedge clk); #1;
    end
    drain();

    // stochastic statistics, then repeat after reset for bit-identical output
    outq.delete();
    sb = mkb(0, 127, mm(23'h000100, 2), 0, 1);
    for (int i = 0; i < 800; i++) send(sb);
    drain();
    chk("sto_count", outq.size(), 800);
    run1 = outq;
    ups = 0;
    foreach (run1[i]) if (run1[i].mant == 23'h000101) ups++;
    checks++;
    if (ups < 176 || ups > 224) begin
      errors++;
      $display("FAIL sto_roundups: got %0d want 176..224", ups);
    end
    do_reset();
    outq.delete();
    for (int i = 0; i < 800; i++) send(sb);
    drain();
    chk("sto_repeat_count", outq.size(), 800);
    mism = 0;
    for (int i = 0; i < 800 && i < outq.size(); i++) if (outq[i] !== run1[i]) mism++;
    chk("sto_repeat_mismatches", mism, 0);

    // backpressure: two beats buffer, outputs hold, all ten emerge in order
    for (int k = 0; k < 10; k++) bp[k] = mkb(k[0], 100 + k, mm(1000 * k, k % 8), 0, 0);
    e0 = emitted;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(bp[0]);
    send(bp[1]);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_hold_0", dut_res(), model(bp[0], 0));
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold", dut_res(), model(bp[0], 0));
      chk("bp_in_ready_still_low", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 2; k < 10; k++) send(bp[k]);
    drain();
    chk("bp_emitted", emitted - e0, 10);

    // reset mid-stream: output drops at once, nothing stale afterwards
    @(posedge clk); #1;
    in_valid = 1'b1;
    {in_sign, in_exp, in_mant, in_lz, rnd_mode} = mkb(0, 120, mm(7, 3), 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_mid_valid_drop", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_no_stale", stale, 0);
    send(mkb(1, 60, mm(9, 6), 2, 0));
    drain();

    // randomized stream with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(rand_beat());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
